// File: rtl/fitbit_tracker.sv
// Step tracker: counts steps from a synchronous pulse level, derives distance,
// early-activity seconds and sustained high-activity time, and drives a
// clamped 4-digit display value selected by SEL.
module fitbit_tracker #(
    parameter int TICKS_PER_SEC   = 100000000,
    parameter int STEPS_PER_TENTH = 205,
    parameter int INIT_SECONDS    = 9,
    parameter int INIT_THRESH     = 32,
    parameter int HIGH_THRESH     = 64,
    parameter int HIGH_MIN_RUN    = 60,
    parameter int SI_LIMIT        = 9999,
    parameter int CNT_W           = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             PULSE,
    input  logic [1:0]       SEL,
    output logic [CNT_W-1:0] step_count,
    output logic [15:0]      distance,
    output logic [3:0]       init_count,
    output logic [15:0]      high_time,
    output logic             SI,
    output logic [13:0]      disp_value
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SUB_W  = $clog2(STEPS_PER_TENTH + 1);
    localparam int RUN_W  = $clog2(HIGH_MIN_RUN + 1);
    localparam int MUX_W  = (CNT_W > 16) ? CNT_W : 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        PEND = 2'd2,
        HIGH = 2'd3
    } state_t;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return val + 16'd1;
        end
    endfunction

    // 16-bit addition that sticks at all-ones on overflow
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    // Limit a metric to what four decimal digits can show
    function automatic logic [13:0] clamp_disp(input logic [MUX_W-1:0] val);
        if (val > MUX_W'(9999)) begin
            return 14'd9999;
        end else begin
            return val[13:0];
        end
    endfunction

    logic                 pulse_prev_r;
    logic [TICK_W-1:0]    tick_r;
    logic [15:0]          elapsed_sec_r;
    logic [CNT_W-1:0]     steps_this_sec_r;
    logic [SUB_W-1:0]     sub_cnt_r;
    logic [CNT_W-1:0]     step_count_r;
    logic [15:0]          distance_r;
    logic [3:0]           init_count_r;
    logic [15:0]          high_time_r;
    logic                 si_r;
    logic [RUN_W-1:0]     run_r;
    state_t               state_r;

    logic                 step_s;
    logic                 sec_tick_s;
    logic                 qual_s;
    state_t               state_next_s;
    logic [RUN_W-1:0]     run_next_s;
    logic [15:0]          high_next_s;
    logic [MUX_W-1:0]     mux_val_s;

    // A step is a rising PULSE level while tracking is enabled
    assign step_s     = START & PULSE & ~pulse_prev_r;
    // One-cycle strobe in the cycle the tick counter wraps
    assign sec_tick_s = START & (tick_r == TICK_W'(TICKS_PER_SEC - 1));
    // The second just finishing counts as high activity
    assign qual_s     = (steps_this_sec_r >= CNT_W'(HIGH_THRESH));

    // Edge-detect history follows PULSE every cycle, even while paused
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pulse_prev_r <= 1'b0;
        end else begin
            pulse_prev_r <= PULSE;
        end
    end

    // Second timebase: runs only while tracking, holds while paused
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tick_r        <= '0;
            elapsed_sec_r <= 16'd0;
        end else if (sec_tick_s) begin
            tick_r        <= '0;
            elapsed_sec_r <= sat_inc16(elapsed_sec_r);
        end else if (START) begin
            tick_r        <= tick_r + TICK_W'(1);
        end
    end

    // Per-second step tally; a step on the wrap cycle opens the new second
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            steps_this_sec_r <= '0;
        end else if (sec_tick_s) begin
            steps_this_sec_r <= step_s ? CNT_W'(1) : CNT_W'(0);
        end else if (step_s) begin
            steps_this_sec_r <= steps_this_sec_r + CNT_W'(1);
        end
    end

    // Qualifying seconds inside the initial window
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            init_count_r <= 4'd0;
        end else if (sec_tick_s && (elapsed_sec_r < 16'(INIT_SECONDS)) &&
                     (steps_this_sec_r > CNT_W'(INIT_THRESH)) && (init_count_r != 4'd15)) begin
            init_count_r <= init_count_r + 4'd1;
        end
    end

    // Total steps and distance in tenths via a steps-per-tenth sub-counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step_count_r <= '0;
            sub_cnt_r    <= '0;
            distance_r   <= 16'd0;
        end else if (step_s) begin
            if (step_count_r != {CNT_W{1'b1}}) begin
                step_count_r <= step_count_r + CNT_W'(1);
            end
            if (sub_cnt_r == SUB_W'(STEPS_PER_TENTH - 1)) begin
                sub_cnt_r  <= '0;
                distance_r <= sat_inc16(distance_r);
            end else begin
                sub_cnt_r  <= sub_cnt_r + SUB_W'(1);
            end
        end
    end

    // Sticky over-limit flag, registered one cycle behind the count
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            si_r <= 1'b0;
        end else if (step_count_r > CNT_W'(SI_LIMIT)) begin
            si_r <= 1'b1;
        end
    end

    // High-activity FSM state, run length and credited time
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= IDLE;
            run_r       <= '0;
            high_time_r <= 16'd0;
        end else begin
            state_r     <= state_next_s;
            run_r       <= run_next_s;
            high_time_r <= high_next_s;
        end
    end

    // High-activity next state: credit only after HIGH_MIN_RUN straight seconds
    always_comb begin
        state_next_s = state_r;
        run_next_s   = run_r;
        high_next_s  = high_time_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    state_next_s = LOW;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOW: begin
                if (sec_tick_s && qual_s) begin
                    run_next_s   = RUN_W'(1);
                    state_next_s = PEND;
                end else begin
                    state_next_s = LOW;
                end
            end
            PEND: begin
                if (sec_tick_s) begin
                    if (!qual_s) begin
                        run_next_s   = '0;
                        state_next_s = LOW;
                    end else if ((run_r + RUN_W'(1)) == RUN_W'(HIGH_MIN_RUN)) begin
                        run_next_s   = run_r + RUN_W'(1);
                        high_next_s  = sat_add16(high_time_r, 16'(HIGH_MIN_RUN));
                        state_next_s = HIGH;
                    end else begin
                        run_next_s   = run_r + RUN_W'(1);
                    end
                end else begin
                    state_next_s = PEND;
                end
            end
            HIGH: begin
                if (sec_tick_s) begin
                    if (qual_s) begin
                        high_next_s  = sat_inc16(high_time_r);
                    end else begin
                        run_next_s   = '0;
                        state_next_s = LOW;
                    end
                end else begin
                    state_next_s = HIGH;
                end
            end
            default: begin
                run_next_s   = '0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Display source select, widened to a common width before clamping
    always_comb begin
        mux_val_s = '0;
        case (SEL)
            2'd0:    mux_val_s = MUX_W'(step_count_r);
            2'd1:    mux_val_s = MUX_W'(distance_r);
            2'd2:    mux_val_s = MUX_W'(init_count_r);
            2'd3:    mux_val_s = MUX_W'(high_time_r);
            default: mux_val_s = '0;
        endcase
    end

    assign disp_value = clamp_disp(mux_val_s);
    assign step_count = step_count_r;
    assign distance   = distance_r;
    assign init_count = init_count_r;
    assign high_time  = high_time_r;
    assign SI         = si_r;

endmodule

// File: tb/tb_fitbit_tracker.sv
// Scoreboarded bench for fitbit_tracker: the driver pushes expected values
// derived from per-second step histories; a monitor pops and compares.
module tb_fitbit_tracker;

    localparam int TPS  = 10;
    localparam int SPT  = 4;
    localparam int INIS = 9;
    localparam int ITH  = 2;
    localparam int HTH  = 2;
    localparam int HMR  = 3;
    localparam int SIL  = 9999;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        PULSE = 1'b0;
    logic [1:0]  SEL   = 2'd0;
    logic [31:0] step_count;
    logic [15:0] distance;
    logic [3:0]  init_count;
    logic [15:0] high_time;
    logic        SI;
    logic [13:0] disp_value;

    fitbit_tracker #(
        .TICKS_PER_SEC(TPS), .STEPS_PER_TENTH(SPT), .INIT_SECONDS(INIS),
        .INIT_THRESH(ITH), .HIGH_THRESH(HTH), .HIGH_MIN_RUN(HMR),
        .SI_LIMIT(SIL), .CNT_W(32)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .PULSE(PULSE), .SEL(SEL),
        .step_count(step_count), .distance(distance), .init_count(init_count),
        .high_time(high_time), .SI(SI), .disp_value(disp_value)
    );

    always #5 CLK = ~CLK;

    // Scoreboard
    string  q_name[$];
    int     q_kind[$];
    longint q_exp[$];
    int     n_vec  = 0;
    int     n_fail = 0;

    // Reference model state: whole aligned seconds plus running step total
    int     sec_steps[$];
    longint m_steps = 0;

    localparam int K_STEP = 0, K_DIST = 1, K_INIT = 2, K_HIGH = 3, K_SI = 4, K_DISP = 5, K_ELAP = 6;

    function automatic longint lmin(longint a, longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic longint m_dist();
        return lmin(m_steps / SPT, 65535);
    endfunction

    function automatic longint m_init();
        longint c = 0;
        for (int i = 0; i < sec_steps.size() && i < INIS; i++)
            if (sec_steps[i] > ITH) c++;
        return lmin(c, 15);
    endfunction

    // A streak of L qualifying seconds earns L seconds once L reaches HMR
    function automatic longint m_high();
        longint h = 0;
        longint len = 0;
        for (int i = 0; i < sec_steps.size(); i++) begin
            if (sec_steps[i] >= HTH) begin
                len++;
            end else begin
                if (len >= HMR) h += len;
                len = 0;
            end
        end
        if (len >= HMR) h += len;
        return lmin(h, 65535);
    endfunction

    function automatic longint clamp(longint v);
        return lmin(v, 9999);
    endfunction

    task automatic expect_v(input string name, input int kind, input longint v);
        q_name.push_back(name);
        q_kind.push_back(kind);
        q_exp.push_back(v);
    endtask

    // Monitor: compare everything queued shortly after each negedge or reset rise
    initial begin : monitor
        logic [63:0] act;
        string nm;
        int k;
        longint ex;
        forever begin
            @(negedge CLK or posedge RESET);
            #1;
            while (q_kind.size() > 0) begin
                nm = q_name.pop_front();
                k  = q_kind.pop_front();
                ex = q_exp.pop_front();
                case (k)
                    K_STEP:  act = 64'(step_count);
                    K_DIST:  act = 64'(distance);
                    K_INIT:  act = 64'(init_count);
                    K_HIGH:  act = 64'(high_time);
                    K_SI:    act = 64'(SI);
                    K_DISP:  act = 64'(disp_value);
                    K_ELAP:  act = 64'(dut.elapsed_sec_r);
                    default: act = 64'hFFFF_FFFF_FFFF_FFFF;
                endcase
                n_vec++;
                if (act !== 64'(ex)) begin
                    n_fail++;
                    $display("FAIL %s: got %0d, expected %0d", nm, act, ex);
                end
            end
        end
    end

    // Wait (bounded) for the monitor to consume the queue, end on a negedge
    task automatic drain();
        #2;
        for (int i = 0; i < 4 && q_kind.size() != 0; i++) #10;
        if (q_kind.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q_kind.size());
            q_name.delete(); q_kind.delete(); q_exp.delete();
        end
        @(negedge CLK);
    endtask

    task automatic cycle(input bit p);
        PULSE = p;
        @(negedge CLK);
    endtask

    // One aligned second with n (0..4) isolated rises on odd ticks before the wrap
    task automatic run_second(input int n);
        START = 1'b1;
        for (int t = 0; t < TPS; t++)
            cycle((t % 2 == 1) && (t <= 7) && (t / 2 < n));
        sec_steps.push_back(n);
        m_steps += n;
    endtask

    task automatic checkpoint(input string tag);
        START = 1'b0;
        PULSE = 1'b0;
        @(negedge CLK);
        expect_v({tag, "_steps"}, K_STEP, m_steps);
        expect_v({tag, "_dist"},  K_DIST, m_dist());
        expect_v({tag, "_init"},  K_INIT, m_init());
        expect_v({tag, "_high"},  K_HIGH, m_high());
        expect_v({tag, "_elap"},  K_ELAP, longint'(sec_steps.size()));
        expect_v({tag, "_si"},    K_SI,   (m_steps > SIL) ? 1 : 0);
        drain();
        for (int s = 0; s < 4; s++) begin
            SEL = 2'(s);
            case (s)
                0:       expect_v({tag, "_disp0"}, K_DISP, clamp(m_steps));
                1:       expect_v({tag, "_disp1"}, K_DISP, clamp(m_dist()));
                2:       expect_v({tag, "_disp2"}, K_DISP, clamp(m_init()));
                default: expect_v({tag, "_disp3"}, K_DISP, clamp(m_high()));
            endcase
            drain();
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        START = 1'b0;
        PULSE = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        sec_steps.delete();
        m_steps = 0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        bit pat[$];
        int rises;
        bit prev;
        int dir39[$];
        int dir40[$];
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // State straight out of reset
        checkpoint("reset");

        // Five single-cycle rises then one level held for three cycles
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rises = 0;
        prev  = 1'b0;
        foreach (pat[i]) begin
            if (pat[i] && !prev) rises++;
            prev = pat[i];
        end
        START = 1'b1;
        foreach (pat[i]) cycle(pat[i]);
        START = 1'b0;
        @(negedge CLK);
        m_steps = rises;
        expect_v("held_pulse_steps", K_STEP, m_steps);
        expect_v("held_pulse_dist",  K_DIST, m_dist());
        drain();

        // Initial window: tenth second must not be counted
        do_reset();
        dir39 = '{3, 1, 3, 3, 0, 3, 3, 3, 3, 3};
        foreach (dir39[i]) run_second(dir39[i]);
        checkpoint("init_win");

        // High-activity streaks, then a qualifying second that must not credit
        do_reset();
        dir40 = '{2, 2, 1, 2, 2, 2, 2, 0};
        foreach (dir40[i]) run_second(dir40[i]);
        checkpoint("high_run");
        run_second(2);
        checkpoint("high_after_low");

        // Pause mid-second with PULSE toggling, then finish the second
        START = 1'b1;
        cycle(1'b0); cycle(1'b1); cycle(1'b0); cycle(1'b0);
        m_steps += 1;
        START = 1'b0;
        for (int i = 0; i < 25; i++) cycle((i % 2 == 0) && (i < 24));
        expect_v("pause_steps", K_STEP, m_steps);
        expect_v("pause_elap",  K_ELAP, longint'(sec_steps.size()));
        drain();
        START = 1'b1;
        cycle(1'b0); cycle(1'b1); cycle(1'b0); cycle(1'b0); cycle(1'b0);
        m_steps += 1;
        START = 1'b0;
        expect_v("resume_before_wrap_elap", K_ELAP, longint'(sec_steps.size()));
        drain();
        START = 1'b1;
        cycle(1'b0);
        sec_steps.push_back(2);
        checkpoint("resume_wrap");

        // Randomised per-second activity
        for (int r = 0; r < 3; r++) begin
            do_reset();
            run_second(4);
            for (int s = 0; s < 19; s++) run_second(int'($urandom_range(0, 4)));
            checkpoint($sformatf("rand%0d", r));
        end

        // Reset asserted between edges clears outputs before the next edge
        SEL = 2'd0;
        @(negedge CLK);
        #2;
        expect_v("async_rst_steps", K_STEP, 0);
        expect_v("async_rst_dist",  K_DIST, 0);
        expect_v("async_rst_init",  K_INIT, 0);
        expect_v("async_rst_high",  K_HIGH, 0);
        expect_v("async_rst_si",    K_SI,   0);
        expect_v("async_rst_disp",  K_DISP, 0);
        RESET = 1'b1;
        #2;
        if (q_kind.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL async_rst_pending: got %0d pending, expected 0", q_kind.size());
            q_name.delete(); q_kind.delete(); q_exp.delete();
        end
        @(negedge CLK);
        RESET = 1'b0;
        sec_steps.delete();
        m_steps = 0;

        // Distance from 9 steps, then the step-limit boundary
        START = 1'b1;
        for (int i = 0; i < 9; i++) begin cycle(1'b1); cycle(1'b0); end
        m_steps = 9;
        START = 1'b0;
        @(negedge CLK);
        expect_v("nine_steps", K_STEP, m_steps);
        expect_v("nine_dist",  K_DIST, m_dist());
        expect_v("nine_si",    K_SI,   0);
        drain();
        START = 1'b1;
        for (int i = 0; i < 9990; i++) begin cycle(1'b1); cycle(1'b0); end
        m_steps += 9990;
        START = 1'b0;
        repeat (2) @(negedge CLK);
        SEL = 2'd0;
        expect_v("at_limit_steps", K_STEP, m_steps);
        expect_v("at_limit_si",    K_SI,   (m_steps > SIL) ? 1 : 0);
        expect_v("at_limit_disp0", K_DISP, clamp(m_steps));
        drain();
        START = 1'b1;
        cycle(1'b1);
        cycle(1'b0);
        m_steps += 1;
        START = 1'b0;
        @(negedge CLK);
        expect_v("over_limit_steps", K_STEP, m_steps);
        expect_v("over_limit_si",    K_SI,   (m_steps > SIL) ? 1 : 0);
        expect_v("over_limit_disp0", K_DISP, clamp(m_steps));
        expect_v("over_limit_dist",  K_DIST, m_dist());
        drain();
        SEL = 2'd1;
        expect_v("over_limit_disp1", K_DISP, clamp(m_dist()));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
